scv_bus_sched: RTL and testbench

- Time-slot scheduler between the uPD7800 CPU core and the console's single-port external memory.
- Generates the four CPU phase-enable strobes from CLK.
- Gives the CPU one fixed memory slot per 4-cycle CPU clock.
- Hands all other cycles, plus unused CPU slots, to a video-fetch requester through a req/ack handshake.
- Sits between upd7800 (A/DB_I/DB_O) and the shared RAM/ROM array in the SCV top level.

---
 rtl/scv_bus_sched.sv | 74 +++++++
 tb/tb_scv_bus_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scv_bus_sched.sv
// scv_bus_sched: phase-strobe generator and CPU/video time-slot arbiter for the shared memory port
module scv_bus_sched #(
  parameter int CPU_SLOT = 1,
  parameter int AW = 16
) (
  input  logic          CLK,
  input  logic          RES,
  output logic          CP1_POSEDGE,
  output logic          CP1_NEGEDGE,
  output logic          CP2_POSEDGE,
  output logic          CP2_NEGEDGE,
  input  logic [AW-1:0] CPU_A,
  input  logic          CPU_RD,
  input  logic          CPU_WR,
  input  logic [7:0]    CPU_DO,
  output logic [7:0]    CPU_DI,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_A,
  output logic          VID_ACK,
  output logic          VID_DV,
  output logic [7:0]    VID_D,
  output logic [AW-1:0] MEM_A,
  output logic          MEM_WE,
  output logic [7:0]    MEM_DO,
  input  logic [7:0]    MEM_DI,
  output logic [1:0]    OWNER
);
  localparam logic [1:0] SLOT = 2'(CPU_SLOT);
  logic          r_run;
  logic [1:0]    r_ph, r_tag1, r_tag2;
  logic [AW-1:0] r_mem_a;
  logic [7:0]    r_cpu_di, r_vid_d;
  logic          w_act, w_cpu, w_vid;
  logic [1:0]    w_tag;
  // Reset gates everything combinationally so a grant in the reset cycle never escapes
  always_comb begin
    w_act = r_run & ~RES;
    w_cpu = w_act & (r_ph == SLOT) & (CPU_RD | CPU_WR);
    w_vid = w_act & ~w_cpu & VID_REQ;
    w_tag = (w_cpu & ~CPU_WR) ? 2'd1 : w_vid ? 2'd2 : 2'd0;
  end
  assign CP1_POSEDGE = w_act & (r_ph == 2'd0);
  assign CP1_NEGEDGE = w_act & (r_ph == 2'd1);
  assign CP2_POSEDGE = w_act & (r_ph == 2'd2);
  assign CP2_NEGEDGE = w_act & (r_ph == 2'd3);
  assign OWNER   = w_cpu ? 2'd1 : w_vid ? 2'd2 : 2'd0;
  assign MEM_A   = RES ? '0 : w_cpu ? CPU_A : w_vid ? VID_A : r_mem_a;
  assign MEM_WE  = w_cpu & CPU_WR;
  assign MEM_DO  = w_cpu ? CPU_DO : 8'h00;
  assign VID_ACK = w_vid;
  assign VID_DV  = ~RES & (r_tag2 == 2'd2);
  assign VID_D   = r_vid_d;
  assign CPU_DI  = r_cpu_di;
  // r_tag1/r_tag2 hold the read owner issued one and two cycles ago; MEM_DI belongs to r_tag1
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_run    <= 1'b0;
      r_ph     <= 2'd0;
      r_tag1   <= 2'd0;
      r_tag2   <= 2'd0;
      r_mem_a  <= '0;
      r_cpu_di <= 8'h00;
      r_vid_d  <= 8'h00;
    end else begin
      r_run   <= 1'b1;
      r_ph    <= r_run ? r_ph + 2'd1 : 2'd0;
      r_tag1  <= w_tag;
      r_tag2  <= r_tag1;
      r_mem_a <= MEM_A;
      if (r_tag1 == 2'd1) r_cpu_di <= MEM_DI;
      if (r_tag1 == 2'd2) r_vid_d <= MEM_DI;
    end
  end
endmodule

// File: tb/tb_scv_bus_sched.sv
// tb_scv_bus_sched: table-driven phase/slot checks, reset corner sequences, randomized model comparison
module tb_scv_bus_sched;
  logic        CLK, RES;
  logic        CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE;
  logic [15:0] CPU_A, VID_A, MEM_A;
  logic        CPU_RD, CPU_WR, VID_REQ, VID_ACK, VID_DV, MEM_WE;
  logic [7:0]  CPU_DO, CPU_DI, VID_D, MEM_DO, mem_di;
  logic [1:0]  OWNER;
  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  mem [0:65535];
  logic [7:0]  ref_mem [0:65535];

  scv_bus_sched #(.CPU_SLOT(1), .AW(16)) dut (
    .CLK(CLK), .RES(RES),
    .CP1_POSEDGE(CP1_POSEDGE), .CP1_NEGEDGE(CP1_NEGEDGE),
    .CP2_POSEDGE(CP2_POSEDGE), .CP2_NEGEDGE(CP2_NEGEDGE),
    .CPU_A(CPU_A), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR), .CPU_DO(CPU_DO), .CPU_DI(CPU_DI),
    .VID_REQ(VID_REQ), .VID_A(VID_A), .VID_ACK(VID_ACK), .VID_DV(VID_DV), .VID_D(VID_D),
    .MEM_A(MEM_A), .MEM_WE(MEM_WE), .MEM_DO(MEM_DO), .MEM_DI(mem_di), .OWNER(OWNER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return (a == 16'h0123) ? 8'h5A : a[7:0] ^ a[15:8];
  endfunction

  // single-port memory: data for the address of cycle t is on mem_di during t+1
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_byte(16'(i));
    forever begin
      @(posedge CLK);
      if (MEM_WE) mem[MEM_A] <= MEM_DO;
      mem_di <= mem[MEM_A];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {CP2_NEGEDGE, CP2_POSEDGE, CP1_NEGEDGE, CP1_POSEDGE};
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_strobes"}, 32'(strobes()), 32'h0);
    chk({nm, "_owner"}, 32'(OWNER), 32'h0);
    chk({nm, "_ack"}, 32'(VID_ACK), 32'h0);
    chk({nm, "_dv"}, 32'(VID_DV), 32'h0);
    chk({nm, "_we"}, 32'(MEM_WE), 32'h0);
    chk({nm, "_mem_a"}, 32'(MEM_A), 32'h0);
  endtask

  typedef struct {
    logic       rd, wr, vreq;
    logic [1:0] own;
    logic       ack, we, dv, chk_di;
    logic [7:0] di;
  } vec_t;

  function automatic vec_t mk(input logic rd, wr, vreq, input logic [1:0] own,
                              input logic ack, we, dv, chk_di, input logic [7:0] di);
    vec_t v;
    v.rd = rd; v.wr = wr; v.vreq = vreq; v.own = own;
    v.ack = ack; v.we = we; v.dv = dv; v.chk_di = chk_di; v.di = di;
    return v;
  endfunction

  initial begin
    vec_t tbl [20];
    logic [1:0] ret_kind [int];
    logic [7:0] ret_data [int];
    logic [7:0] exp_di;
    int n_ack, n_dv;
    // rows start at phase 0 right after run begins; row i is in phase i%4
    tbl[0]  = mk(0,0,0, 2'd0, 0,0,0, 0,8'h00);
    tbl[1]  = mk(0,0,0, 2'd0, 0,0,0, 0,8'h00);
    tbl[2]  = mk(0,0,0, 2'd0, 0,0,0, 0,8'h00);
    tbl[3]  = mk(0,0,0, 2'd0, 0,0,0, 0,8'h00);
    tbl[4]  = mk(1,0,0, 2'd0, 0,0,0, 0,8'h00);
    tbl[5]  = mk(1,0,0, 2'd1, 0,0,0, 1,8'h00);
    tbl[6]  = mk(1,0,0, 2'd0, 0,0,0, 1,8'h00);
    tbl[7]  = mk(1,0,0, 2'd0, 0,0,0, 1,8'h5A);
    tbl[8]  = mk(0,1,0, 2'd0, 0,0,0, 0,8'h00);
    tbl[9]  = mk(0,1,0, 2'd1, 0,1,0, 1,8'h5A);
    tbl[10] = mk(0,1,0, 2'd0, 0,0,0, 0,8'h00);
    tbl[11] = mk(0,1,0, 2'd0, 0,0,0, 1,8'h5A);
    tbl[12] = mk(1,0,1, 2'd2, 1,0,0, 0,8'h00);
    tbl[13] = mk(1,0,1, 2'd1, 0,0,0, 0,8'h00);
    tbl[14] = mk(1,0,1, 2'd2, 1,0,1, 0,8'h00);
    tbl[15] = mk(1,0,1, 2'd2, 1,0,0, 1,8'h5A);
    tbl[16] = mk(0,0,1, 2'd2, 1,0,1, 0,8'h00);
    tbl[17] = mk(0,0,1, 2'd2, 1,0,1, 0,8'h00);
    tbl[18] = mk(0,0,1, 2'd2, 1,0,1, 0,8'h00);
    tbl[19] = mk(0,0,1, 2'd2, 1,0,1, 0,8'h00);
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
    RES = 1'b1; CPU_RD = 0; CPU_WR = 0; CPU_DO = 8'h00; CPU_A = 16'h0; VID_REQ = 0; VID_A = 16'h0;
    repeat (3) next_cycle();
    @(negedge CLK);
    chk_quiet("reset");
    chk("reset_cpu_di", 32'(CPU_DI), 32'h0);
    chk("reset_vid_d", 32'(VID_D), 32'h0);
    next_cycle();
    RES = 1'b0;
    @(negedge CLK);
    chk("prerun_strobes", 32'(strobes()), 32'h0);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      CPU_RD = tbl[i].rd; CPU_WR = tbl[i].wr; VID_REQ = tbl[i].vreq;
      CPU_A = tbl[i].wr ? 16'h2000 : 16'h0123; CPU_DO = 8'hC3; VID_A = 16'h3000;
      @(negedge CLK);
      chk($sformatf("tbl%0d_strobes", i), 32'(strobes()), 32'(4'b0001 << (i % 4)));
      chk($sformatf("tbl%0d_owner", i), 32'(OWNER), 32'(tbl[i].own));
      chk($sformatf("tbl%0d_ack", i), 32'(VID_ACK), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_we", i), 32'(MEM_WE), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_dv", i), 32'(VID_DV), 32'(tbl[i].dv));
      if (tbl[i].own != 2'd0)
        chk($sformatf("tbl%0d_mem_a", i), 32'(MEM_A), tbl[i].own == 2'd1 ? 32'(CPU_A) : 32'h3000);
      if (tbl[i].we) chk($sformatf("tbl%0d_mem_do", i), 32'(MEM_DO), 32'hC3);
      if (tbl[i].dv) chk($sformatf("tbl%0d_vid_d", i), 32'(VID_D), 32'(ref_mem[16'h3000]));
      if (tbl[i].chk_di) chk($sformatf("tbl%0d_cpu_di", i), 32'(CPU_DI), 32'(tbl[i].di));
      next_cycle();
    end
    chk("write_landed", 32'(mem[16'h2000]), 32'hC3);
    ref_mem[16'h2000] = 8'hC3;
    // reset arrives in the cycle after a grant: that fetch must vanish
    CPU_RD = 0; CPU_WR = 0; VID_REQ = 1; VID_A = 16'h3001;
    @(negedge CLK);
    chk("midrst_grant", 32'(VID_ACK), 32'h1);
    next_cycle();
    RES = 1'b1; VID_REQ = 0;
    @(negedge CLK);
    chk_quiet("midrst_first");
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge CLK);
      chk($sformatf("midrst%0d_dv", i), 32'(VID_DV), 32'h0);
      chk($sformatf("midrst%0d_cpu_di", i), 32'(CPU_DI), 32'h0);
    end
    next_cycle();
    RES = 1'b0;
    @(negedge CLK);
    chk("midrst_prerun_dv", 32'(VID_DV), 32'h0);
    chk("midrst_prerun_strobes", 32'(strobes()), 32'h0);
    next_cycle();
    @(negedge CLK);
    chk("restart_ph0", 32'(strobes()), 32'h1);
    chk("restart_dv", 32'(VID_DV), 32'h0);
    next_cycle();
    @(negedge CLK);
    chk("restart_ph1", 32'(strobes()), 32'h2);
    next_cycle();
    // randomized traffic against a slot/return model; loop begins in phase 2
    exp_di = 8'h00; n_ack = 0; n_dv = 0;
    for (int c = 0; c < 600; c++) begin
      int p;
      logic cpu, vid, rd, wr;
      p = (c + 2) % 4;
      rd = 1'($urandom_range(0, 1)); wr = ($urandom_range(0, 3) == 0);
      CPU_RD = rd; CPU_WR = wr; VID_REQ = ($urandom_range(0, 3) != 0);
      CPU_A = 16'h0100 | 16'($urandom_range(0, 255));
      VID_A = 16'h0100 | 16'($urandom_range(0, 255));
      CPU_DO = 8'($urandom);
      cpu = (p == 1) && (rd || wr);
      vid = !cpu && VID_REQ;
      @(negedge CLK);
      chk("rnd_strobes", 32'(strobes()), 32'(4'b0001 << p));
      chk("rnd_owner", 32'(OWNER), cpu ? 32'h1 : vid ? 32'h2 : 32'h0);
      chk("rnd_ack", 32'(VID_ACK), 32'(vid));
      chk("rnd_we", 32'(MEM_WE), 32'(cpu && wr));
      if (cpu || vid) chk("rnd_mem_a", 32'(MEM_A), cpu ? 32'(CPU_A) : 32'(VID_A));
      if (cpu && wr) chk("rnd_mem_do", 32'(MEM_DO), 32'(CPU_DO));
      if (ret_kind.exists(c - 2) && ret_kind[c - 2] == 2'd1) exp_di = ret_data[c - 2];
      chk("rnd_dv", 32'(VID_DV), 32'(ret_kind.exists(c - 2) && ret_kind[c - 2] == 2'd2));
      if (ret_kind.exists(c - 2) && ret_kind[c - 2] == 2'd2) chk("rnd_vid_d", 32'(VID_D), 32'(ret_data[c - 2]));
      chk("rnd_cpu_di", 32'(CPU_DI), 32'(exp_di));
      if (cpu && !wr) begin ret_kind[c] = 2'd1; ret_data[c] = ref_mem[CPU_A]; end
      if (vid) begin ret_kind[c] = 2'd2; ret_data[c] = ref_mem[VID_A]; n_ack++; end
      if (cpu && wr) ref_mem[CPU_A] = CPU_DO;
      if (VID_DV) n_dv++;
      next_cycle();
    end
    CPU_RD = 0; CPU_WR = 0; VID_REQ = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      if (VID_DV) n_dv++;
      next_cycle();
    end
    chk("rnd_ack_dv_count", 32'(n_dv), 32'(n_ack));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
